// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: debounced A/B/op entry front-end for the 4-bit calculator ALU
//
// Ports:
//   clk, rst_n              - clock (rising edge) and asynchronous active-low reset
//   sw[3:0]                 - data switches, captured as operand A or B
//   sw_type, sw_sel[1:0]    - op-type / op-select switches, captured in the op stage
//   btn_enter, btn_clear    - raw bouncy push-buttons (synchronized + debounced here)
//   a_out, b_out            - captured operands
//   type_out, select_out    - captured op fields
//   operands_valid          - high while a complete A/B/op set is held
//   stage[1:0]              - current entry stage for LEDs
module calc_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       sw_type,
  input  logic [1:0] sw_sel,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       type_out,
  output logic [1:0] select_out,
  output logic       operands_valid,
  output logic [1:0] stage
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_DONE = 2'b11} state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_clear, btn_enter};

  // Per button: 2-flop synchronizer, stability counter, debounced level and its
  // one-cycle-delayed copy for rising-edge detection.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic          s1_q, s2_q, db_q, dbp_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        db_q  <= 1'b0;
        dbp_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn_raw[i];
        s2_q  <= s1_q;
        dbp_q <= db_q;
        if (s2_q == db_q) cnt_q <= '0;
        else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q <= '0;
          db_q  <= ~db_q;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign press[i] = db_q & ~dbp_q;
  end

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       type_q, type_d, valid_q, valid_d;
  logic [1:0] sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    type_d  = type_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    // Clear takes priority; a coincident enter is dropped.
    if (press[1]) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      type_d  = 1'b0;
      sel_d   = '0;
      valid_d = 1'b0;
    end else if (press[0]) begin
      case (state_q)
        S_A: begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: begin
          type_d  = sw_type;
          sel_d   = sw_sel;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        default: begin
          a_d     = sw;
          valid_d = 1'b0;
          state_d = S_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      type_q  <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      type_q  <= type_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign type_out       = type_q;
  assign select_out     = sel_q;
  assign operands_valid = valid_q;
  assign stage          = state_q;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb_calc_operand_sequencer: randomized + directed bench against a behavioural entry model
module tb_calc_operand_sequencer;
  localparam int D = 4;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic [3:0] sw = '0;
  logic       sw_type = 1'b0;
  logic [1:0] sw_sel = '0;
  logic       btn_enter = 1'b0, btn_clear = 1'b0;
  logic [3:0] a_out, b_out;
  logic       type_out, operands_valid;
  logic [1:0] select_out, stage;

  int     checks = 0, failures = 0;
  longint edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sw_type(sw_type), .sw_sel(sw_sel),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .a_out(a_out), .b_out(b_out),
    .type_out(type_out), .select_out(select_out), .operands_valid(operands_valid),
    .stage(stage)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a button level is accepted once the synchronized input has
  // disagreed with the accepted level for the last D samples; the entry machine
  // acts on an accepted rise one edge later.
  int       m_st;
  bit [3:0] m_a, m_b;
  bit       m_t, m_v;
  bit [1:0] m_s;
  bit       m_s1[2], m_s2[2], m_db[2], m_dbp[2];
  bit       hist[2][D];
  int       n_since[2];

  always @(posedge clk or negedge rst_n) begin
    bit ee, ce, all;
    if (!rst_n) begin
      m_st = 0; m_a = 0; m_b = 0; m_t = 0; m_s = 0; m_v = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0; n_since[b] = 0;
        for (int i = 0; i < D; i++) hist[b][i] = 0;
      end
    end else begin
      ee = m_db[0] & ~m_dbp[0];
      ce = m_db[1] & ~m_dbp[1];
      if (ce) begin
        m_st = 0; m_a = 0; m_b = 0; m_t = 0; m_s = 0; m_v = 0;
      end else if (ee) begin
        case (m_st)
          0: begin m_a = sw; m_st = 1; end
          1: begin m_b = sw; m_st = 2; end
          2: begin m_t = sw_type; m_s = sw_sel; m_v = 1; m_st = 3; end
          default: begin m_a = sw; m_v = 0; m_st = 1; end
        endcase
      end
      for (int b = 0; b < 2; b++) begin
        m_dbp[b] = m_db[b];
        for (int i = D - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = m_s2[b];
        if (n_since[b] < D) n_since[b]++;
        all = 1;
        for (int i = 0; i < D; i++) if (hist[b][i] == m_db[b]) all = 0;
        if (n_since[b] >= D && all) begin
          m_db[b] = ~m_db[b];
          n_since[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = b ? btn_clear : btn_enter;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_out", 8'(a_out), 8'(m_a));
      chk("b_out", 8'(b_out), 8'(m_b));
      chk("type_out", 8'(type_out), 8'(m_t));
      chk("select_out", 8'(select_out), 8'(m_s));
      chk("operands_valid", 8'(operands_valid), 8'(m_v));
      chk("stage", 8'(stage), 8'(m_st));
    end
  end

  task automatic settle();
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic press(input bit clr, input int hold);
    @(negedge clk);
    if (clr) btn_clear = 1'b1; else btn_enter = 1'b1;
    repeat (hold) @(negedge clk);
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    settle();
  endtask

  // Enter press held 20 cycles; checks the capture lands D+2 edges after the first
  // edge that samples the raw button high.
  task automatic press_lat();
    longint k;
    logic [1:0] st0;
    int waited;
    @(negedge clk);
    st0 = stage;
    btn_enter = 1'b1;
    k = edges + 1;
    waited = 0;
    while (stage == st0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("capture_latency", 8'(edges - k), 8'(D + 2));
    repeat (20 - waited) @(negedge clk);
    btn_enter = 1'b0;
    settle();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a", 8'(a_out), 8'h0);
    chk("rst_stage", 8'(stage), 8'h0);
    chk("rst_valid", 8'(operands_valid), 8'h0);
    rst_n = 1'b1;
    settle();

    sw = 4'b0011; press_lat();
    sw = 4'b0101; press_lat();
    sw_type = 1'b0; sw_sel = 2'b00; press_lat();
    chk("full_a", 8'(a_out), 8'h3);
    chk("full_b", 8'(b_out), 8'h5);
    chk("full_type", 8'(type_out), 8'h0);
    chk("full_sel", 8'(select_out), 8'h0);
    chk("full_valid", 8'(operands_valid), 8'h1);
    chk("full_stage", 8'(stage), 8'h3);

    press(1'b1, 20);
    chk("clr_stage", 8'(stage), 8'h0);

    sw = 4'b0111;
    @(negedge clk); btn_enter = 1'b1;
    repeat (2) @(negedge clk); btn_enter = 1'b0;
    @(negedge clk); btn_enter = 1'b1;
    repeat (3) @(negedge clk); btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_stage", 8'(stage), 8'h0);
    chk("bounce_a", 8'(a_out), 8'h0);
    press(1'b0, 20);
    chk("clean_a", 8'(a_out), 8'h7);
    chk("clean_stage", 8'(stage), 8'h1);

    press(1'b1, 20);
    sw = 4'b0001;
    @(negedge clk); btn_enter = 1'b1;
    repeat (100) @(negedge clk);
    sw = 4'b1110;
    repeat (100) @(negedge clk);
    chk("hold_a", 8'(a_out), 8'h1);
    chk("hold_stage", 8'(stage), 8'h1);
    btn_enter = 1'b0;
    settle();
    chk("hold_stage_after", 8'(stage), 8'h1);

    press(1'b1, 20);
    sw = 4'd9; press(1'b0, 20);
    sw = 4'd6; press(1'b0, 20);
    chk("prio_pre_stage", 8'(stage), 8'h2);
    @(negedge clk); btn_enter = 1'b1; btn_clear = 1'b1;
    repeat (20) @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    settle();
    chk("prio_stage", 8'(stage), 8'h0);
    chk("prio_a", 8'(a_out), 8'h0);
    chk("prio_b", 8'(b_out), 8'h0);
    chk("prio_valid", 8'(operands_valid), 8'h0);

    sw = 4'd3; press(1'b0, 20);
    sw = 4'd5; press(1'b0, 20);
    sw_type = 1'b1; sw_sel = 2'b11; press(1'b0, 20);
    chk("done_stage", 8'(stage), 8'h3);
    sw = 4'hF; sw_type = 1'b0; sw_sel = 2'b00; press(1'b0, 20);
    chk("re_a", 8'(a_out), 8'hF);
    chk("re_b", 8'(b_out), 8'h5);
    chk("re_type", 8'(type_out), 8'h1);
    chk("re_sel", 8'(select_out), 8'h3);
    chk("re_valid", 8'(operands_valid), 8'h0);
    chk("re_stage", 8'(stage), 8'h1);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", 8'(a_out), 8'h0);
    chk("arst_b", 8'(b_out), 8'h0);
    chk("arst_type", 8'(type_out), 8'h0);
    chk("arst_sel", 8'(select_out), 8'h0);
    chk("arst_stage", 8'(stage), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sw = 4'hA; press(1'b0, 20);
    chk("post_rst_a", 8'(a_out), 8'hA);
    chk("post_rst_stage", 8'(stage), 8'h1);

    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      sw = 4'($urandom);
      sw_type = 1'($urandom);
      sw_sel = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        btn_enter = 1'b1;
        repeat ($urandom_range(1, D - 1)) @(negedge clk);
        btn_enter = 1'b0;
        @(negedge clk);
      end
      btn_clear = ($urandom_range(0, 5) == 0);
      btn_enter = ~btn_clear | ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      sw = 4'($urandom);
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
